// File: rtl/uart_pkg.sv
// Shared UART definitions: bit timing defaults and transmitter FSM states.
// UART_TX_PARITY_EN adds the PARITY state (8E1 frames); default is 8N1.
package uart_pkg;

  localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 10416;
  localparam int unsigned UART_DATA_BITS_DEFAULT    = 8;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_tx_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } uart_tx_state_t;
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last count as tick.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // clear realigns the bit phase to the start bit of a newly accepted byte
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte in, LSB-first serial frame out on txd.
// UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int unsigned DATA_BITS    = UART_DATA_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy
);

  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_tx_state_t       state;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_nxt_c;
  logic [IDX_W-1:0]     bit_idx;
  logic                 tick;
  logic                 accept_c;
`ifdef UART_TX_PARITY_EN
  logic                 parity;
`endif

  assign accept_c    = tx_valid && tx_ready;
  assign shreg_nxt_c = shreg >> 1;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk  (clk),
    .rst  (rst),
    .clear(accept_c),
    .tick (tick)
  );

  // txd is always loaded with the value of the bit about to start
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      txd      <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            shreg    <= tx_data;
            bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
            parity   <= ^tx_data;
`endif
            state    <= ST_START;
            txd      <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            state <= ST_DATA;
            txd   <= shreg[0];
          end
        end
        ST_DATA: begin
          if (tick) begin
            shreg   <= shreg_nxt_c;
            bit_idx <= bit_idx + IDX_W'(1);
            if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              state <= ST_PARITY;
              txd   <= parity;
`else
              state <= ST_STOP;
              txd   <= 1'b1;
`endif
            end else begin
              txd <= shreg_nxt_c[0];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            state <= ST_STOP;
            txd   <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            state    <= ST_IDLE;
            txd      <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          txd      <= 1'b1;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: per-cycle txd/busy/tx_ready against a frame model.
module tb_uart_tx;

  localparam int unsigned CPB = 7;
  localparam int unsigned DB  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NSLOT = DB + 3;
`else
  localparam int unsigned NSLOT = DB + 2;
`endif
  localparam int unsigned FRAME   = NSLOT * CPB;
  localparam int unsigned ABORT_J = 4 * CPB + CPB / 2;

  localparam int M_NONE  = 0;
  localparam int M_PULSE = 1;
  localparam int M_HOLD  = 2;
  localparam int M_ABORT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       txd;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .txd     (txd),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level for frame slot: start, data LSB first, [parity], stop
  function automatic logic exp_bit(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= int'(DB)) return b[slot-1];
`ifdef UART_TX_PARITY_EN
    if (slot == int'(DB) + 1) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " txd"},   8'(txd),      8'h1);
    check({tag, " ready"}, 8'(tx_ready), 8'h1);
    check({tag, " busy"},  8'(busy),     8'h0);
  endtask

  task automatic send(input logic [7:0] b, input int mode, input logic [7:0] nxt);
    logic [NSLOT-1:0] rx;
    rx = '0;
    check("ready_before", 8'(tx_ready), 8'h1);
    tx_valid = 1'b1;
    tx_data  = b;
    step();
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    for (int j = 0; j < int'(FRAME); j++) begin
      if (mode == M_ABORT && j == int'(ABORT_J)) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("abort");
        return;
      end
      check($sformatf("txd b=%02h j=%0d", b, j), 8'(txd), 8'(exp_bit(b, j / int'(CPB))));
      check($sformatf("busy j=%0d", j),  8'(busy),     8'h1);
      check($sformatf("ready j=%0d", j), 8'(tx_ready), 8'h0);
      if (j % int'(CPB) == int'(CPB / 2)) rx[j / int'(CPB)] = txd;
      if (mode == M_HOLD) begin
        if (j == int'(FRAME / 2)) begin
          tx_valid = 1'b1;
          tx_data  = nxt;
        end
      end else if (j % int'(CPB) == 1) begin
        tx_data = 8'($urandom);
      end
      if (mode == M_PULSE && j == int'(FRAME / 3)) begin
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
      end
      if (mode == M_PULSE && j == int'(FRAME / 3) + 1) tx_valid = 1'b0;
      step();
    end
    check($sformatf("decoded %02h", b), rx[DB:1], b);
    check("start_bit", 8'(rx[0]), 8'h0);
    check("stop_bit",  8'(rx[NSLOT-1]), 8'h1);
    check_idle("post_frame");
  endtask

  initial begin
    logic [7:0] cur;
    logic [7:0] nxt;
    int         mode;

    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) step();
    check_idle("reset");
    rst = 1'b0;
    step();
    check_idle("after_reset");

    send(8'h55, M_NONE, 8'h00);
    send(8'hA3, M_HOLD, 8'h0F);
    send(8'h0F, M_NONE, 8'h00);
    send(8'h96, M_PULSE, 8'h00);
    send(8'hE1, M_ABORT, 8'h00);
    send(8'h3C, M_NONE, 8'h00);

    // reset and a request in the same cycle: reset wins
    tx_valid = 1'b1;
    tx_data  = 8'h77;
    rst      = 1'b1;
    step();
    check_idle("rst_and_valid");
    rst      = 1'b0;
    tx_valid = 1'b0;
    step();
    check_idle("not_accepted");

    send(8'h07, M_NONE, 8'h00);
    send(8'h03, M_NONE, 8'h00);
    send(8'h00, M_NONE, 8'h00);
    send(8'hFF, M_NONE, 8'h00);
    send(8'h5A, M_NONE, 8'h00);

    cur = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      nxt  = 8'($urandom);
      mode = int'($urandom_range(0, 2));
      send(cur, mode, nxt);
      cur = nxt;
    end
    tx_valid = 1'b0;
    repeat (3) step();
    check_idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
